// File: rtl/txbuf_fifo_p.sv
// rtl/txbuf_fifo_p.sv - serial-to-word transmit buffer with FIFO and four-phase dav_tx/ack_tx output
module txbuf_fifo_p #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int LSB_FIRST  = 1,
    parameter int LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    input  logic                  frame_end,
    input  logic                  rfd_tx,
    input  logic                  ack_tx,
    output logic [DATA_W-1:0]     dataout,
    output logic                  last_out,
    output logic                  dav_tx,
    output logic                  ack,
    output logic                  tx_full,
    output logic                  tx_empty,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam int LVL_W = DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, WAIT, PRESENT, RELEASE} state_t;

    logic [CNT_W-1:0]      bitcnt;
    logic [CNT_W-1:0]      idx;
    logic [DATA_W-1:0]     sr;
    logic [DATA_W-1:0]     sr_next;
    logic                  take;
    logic                  word_done;
    logic [DATA_W-1:0]     pend_data;
    logic                  pend_last;
    logic                  pend_valid;
    logic [DATA_W:0]       mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;
    logic [3:0]            latcnt;
    state_t                state;
    state_t                state_next;
    logic                  load_lat;
    logic                  load_out;

    assign take      = start & bit_valid;
    assign word_done = (bitcnt == CNT_W'(DATA_W - 1)) | frame_end;

    // Bits are placed directly at their final position so a short frame is zero-padded for free.
    always_comb begin
        idx          = (LSB_FIRST != 0) ? bitcnt : CNT_W'(DATA_W - 1) - bitcnt;
        sr_next      = sr;
        sr_next[idx] = bit_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitcnt     <= '0;
            sr         <= '0;
            pend_data  <= '0;
            pend_last  <= 1'b0;
            pend_valid <= 1'b0;
        end else begin
            pend_valid <= take & word_done;
            if (!start) begin
                bitcnt <= '0;
                sr     <= '0;
            end else if (bit_valid) begin
                if (word_done) begin
                    bitcnt    <= '0;
                    sr        <= '0;
                    pend_data <= sr_next;
                    pend_last <= frame_end;
                end else begin
                    bitcnt <= bitcnt + 1'b1;
                    sr     <= sr_next;
                end
            end
        end
    end

    assign tx_full  = (level == LVL_W'(DEPTH));
    assign tx_empty = (level == '0);
    assign pop      = (state == PRESENT) & ack_tx;
    assign push     = pend_valid & (!tx_full | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            ack      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ack <= push;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (pend_valid && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {pend_last, pend_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!tx_empty && rfd_tx) state_next = WAIT;
            WAIT:    if (!rfd_tx) state_next = IDLE;
                     else if (latcnt == 4'd0) state_next = PRESENT;
            PRESENT: if (ack_tx) state_next = RELEASE;
            RELEASE: if (!ack_tx) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        load_lat = (state == IDLE) && (state_next == WAIT);
        load_out = (state == WAIT) && (state_next == PRESENT);
        dav_tx   = (state == PRESENT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            latcnt   <= 4'd0;
            dataout  <= '0;
            last_out <= 1'b0;
        end else begin
            if (load_lat)            latcnt <= 4'(LATENCY - 1);
            else if (state == WAIT)  latcnt <= latcnt - 1'b1;
            if (load_out) {last_out, dataout} <= mem[rd_ptr];
        end
    end

endmodule

// File: doc/txbuf_fifo_p.md
Name: txbuf_fifo_p

Overview:
Parametrised transmit buffer for the 1200 bps packet path. It deserialises a gated serial bit stream into DATA_W-bit words with an optional frame-last marker, and stores them in a 2^DEPTH_LOG2-entry FIFO. Words are presented to the transmit stage over a four-phase dav_tx/ack_tx handshake, gated by rfd_tx. Compared with the fixed 8-bit buffer, it adds configurable width, depth, bit order and presentation latency, plus frame marking, fill level and overflow reporting.

Parameters:
DATA_W, 8, word width in bits (2..16)
DEPTH_LOG2, 4, FIFO depth is 2^DEPTH_LOG2 entries (2..8)
LSB_FIRST, 1, 1: first received bit lands in dataout[0]; 0: first bit lands in dataout[DATA_W-1]
LATENCY, 2, cycles from presentation-eligible to dav_tx rise (1..15)

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  capture enable; low discards any partial word and clears the bit counter
bit_in  in  1  serial data bit
bit_valid  in  1  bit_in is sampled this cycle (ignored while start=0)
frame_end  in  1  qualifies bit_valid: this bit is the last of the frame
rfd_tx  in  1  transmit stage ready for data
ack_tx  in  1  transmit stage acknowledge (four-phase)
dataout  out  DATA_W  presented word
last_out  out  1  presented word is last of frame
dav_tx  out  1  data valid to transmit stage
ack  out  1  one-cycle pulse: word written into FIFO
tx_full  out  1  FIFO holds 2^DEPTH_LOG2 words
tx_empty  out  1  FIFO holds 0 words
level  out  DEPTH_LOG2+1  current FIFO occupancy
overflow  out  1  sticky; a word was dropped because the FIFO was full

Behaviour:
- Reset (rst_n=0, asynchronous):
  - dataout=0, last_out=0, dav_tx=0, ack=0, tx_full=0, tx_empty=1, level=0, overflow=0.
  - Bit counter, shift register, pointers and FSM return to IDLE.
  - A reset during a handshake abandons it; the word is lost.
- Deserialiser:
  - On each bit_valid&start, shift in bit_in per LSB_FIRST and increment bitcnt.
  - On the DATA_W-th bit, or any bit with frame_end=1, form the word. A partial word is zero-padded in the positions not yet filled. last is set to frame_end. bitcnt returns to 0.
  - The write is attempted in the cycle after word completion.
- Write:
  - Accepted if !tx_full, or if a pop occurs in the same cycle.
  - On accept, ack pulses high for exactly 1 cycle.
  - On reject, the word is dropped, overflow is set and stays set until reset, and ack stays low.
- Pointers are DEPTH_LOG2 bits wide and wrap modulo depth. level is the registered occupancy. tx_full = (level==2^DEPTH_LOG2), tx_empty = (level==0). Simultaneous push and pop leaves level unchanged.
- Output FSM:
  - IDLE: when !tx_empty & rfd_tx, load latcnt=LATENCY-1 and go to WAIT.
  - WAIT: decrement latcnt each cycle; at 0, register head into dataout/last_out, set dav_tx=1 and go to PRESENT. If rfd_tx drops during WAIT, return to IDLE.
  - PRESENT: hold dav_tx, dataout and last_out stable. When ack_tx=1, pop the FIFO (level-1), clear dav_tx next edge and go to RELEASE. rfd_tx dropping in PRESENT is ignored.
  - RELEASE: wait for ack_tx=0, then go to IDLE. At least one dav_tx-low cycle separates words.
- dataout holds its last value outside PRESENT.
- Minimum per-word output time is LATENCY+3 cycles.

Test Plan:
- Reset, then feed 0xA5 over 8 bits with LSB_FIRST=1 and rfd_tx=1. Expect ack pulse 1 cycle after bit 8, level=1, dav_tx rise LATENCY=2 cycles after the IDLE exit, dataout=0xA5, last_out=0. Raise ack_tx: dav_tx falls, level=0, tx_empty=1.
- Instance with LSB_FIRST=0, DATA_W=8, same bit sequence. Expect dataout=0xA5 bit-reversed, i.e. 0xA5. Then send sequence 1,0,0,0,0,0,0,0. Expect 0x80 (vs 0x01 for LSB_FIRST=1).
- Send 3 bits 1,1,1 with frame_end on the third (LSB_FIRST=1). Expect word 0x07 with last_out=1 and ack pulse.
- DEPTH_LOG2=2, hold rfd_tx=0, write 5 words. Expect tx_full after the 4th and level=4. The 5th word gives no ack and overflow=1, which stays 1 through later pops.
- FIFO full with a word in PRESENT. Complete a new word so its write coincides with the ack_tx pop. Expect the write accepted, ack pulse, level stays 4, overflow stays 0.
- Reset mid-stream: drop rst_n during PRESENT with level=3. Expect dav_tx=0, level=0, tx_empty=1 immediately, without waiting for a clock edge. After release, a partial word from before the reset is not output.
